// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register.
// Holds the control-word width and the bit position of each id_ctrl field.
// Also holds the pipeline-register state encoding and the bubble control word.
package pipe_pkg;

  localparam int unsigned CTRL_W = 10;

  // Bit positions inside the packed control word
  // {regWrite, memRead, memWrite, memToReg, aluSrc, branch, aluOp[3:0]}
  localparam int unsigned CTRL_REG_WRITE  = 9;
  localparam int unsigned CTRL_MEM_READ   = 8;
  localparam int unsigned CTRL_MEM_WRITE  = 7;
  localparam int unsigned CTRL_MEM_TO_REG = 6;
  localparam int unsigned CTRL_ALU_SRC    = 5;
  localparam int unsigned CTRL_BRANCH     = 4;
  localparam int unsigned CTRL_ALU_OP_HI  = 3;
  localparam int unsigned CTRL_ALU_OP_LO  = 0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // A bubble carries no side effects: every control bit is cleared
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Ports: clk, reset (async, active-high), inc (count one event),
//        count (current value; holds at all-ones and never wraps).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/id_ex_bubble_reg.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   hz_stall, flush       - stall request from the hazard detector, branch squash from EX
//   id_*                  - decoded instruction fields from ID
//   ex_*                  - registered fields presented to EX (zero when a bubble)
//   hz_release            - high while EX holds a stall bubble; re-arms the detector
//   bubble_cnt, flush_cnt - saturating counts of stall and flush bubbles
module id_ex_bubble_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hz_stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_valid,
  output logic              hz_release,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // fcnt counts the flush bubbles still owed after the current one
  localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              load_bubble;
  logic              bubble_inc;
  logic              flush_inc;

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    load_bubble = 1'b0;
    bubble_inc  = 1'b0;
    flush_inc   = 1'b0;
    if (flush) begin
      // A flush wins from any state and restarts the squash window
      load_bubble = 1'b1;
      flush_inc   = 1'b1;
      fcnt_d      = FCNT_RELOAD;
      state_d     = (FCNT_RELOAD != '0) ? FLUSH : RUN;
    end else begin
      unique case (state_q)
        FLUSH: begin
          // Stalls are ignored: the slot is squashed anyway
          load_bubble = 1'b1;
          flush_inc   = 1'b1;
          if (fcnt_q <= FCNT_W'(1)) begin
            fcnt_d  = '0;
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - FCNT_W'(1);
          end
        end
        RUN, BUBBLE: begin
          if (hz_stall) begin
            load_bubble = 1'b1;
            bubble_inc  = 1'b1;
            state_d     = BUBBLE;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ctrl     <= BUBBLE_CTRL;
      ex_valid    <= 1'b0;
    end else if (load_bubble) begin
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ctrl     <= BUBBLE_CTRL;
      ex_valid    <= 1'b0;
    end else begin
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_ctrl     <= id_ctrl;
      ex_valid    <= id_valid;
    end
  end

  // Moore output: only a stall bubble releases the detector, never a flush bubble
  assign hz_release = (state_q == BUBBLE);

  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (bubble_inc),
    .count(bubble_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (flush_inc),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_id_ex_bubble_reg.sv
// Self-checking bench for id_ex_bubble_reg (FLUSH_CYCLES=2, CNT_W=4).
module tb_id_ex_bubble_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned FC = 2;
  localparam int unsigned CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int EXW = 4 * DW + 3 * AW + 10 + 1;
  localparam int OBW = EXW + 1 + 2 * CW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hz_stall = 1'b0;
  logic flush = 1'b0;
  logic id_valid = 1'b0;
  logic [DW-1:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [9:0] id_ctrl = '0;
  logic [DW-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [9:0] ex_ctrl;
  logic ex_valid, hz_release;
  logic [CW-1:0] bubble_cnt, flush_cnt;

  id_ex_bubble_reg #(
    .DATA_W(DW), .REG_AW(AW), .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .hz_stall(hz_stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_valid(ex_valid), .hz_release(hz_release),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  logic [EXW-1:0] id_bus;
  logic [OBW-1:0] obs, exp_v;
  assign id_bus = {id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_ctrl,
                   id_valid};
  assign obs = {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
                ex_valid, hz_release, bubble_cnt, flush_cnt};

  // Reference model: what EX holds, how many flush bubbles are still owed,
  // whether the last bubble came from a stall, and the two event counts.
  logic [EXW-1:0] m_ex;
  int m_owed, m_bcnt, m_fcnt;
  bit m_rel;
  int errors = 0;
  int checks = 0;

  assign exp_v = {m_ex, m_rel, CW'(m_bcnt), CW'(m_fcnt)};

  task automatic model_clear();
    m_ex = '0; m_owed = 0; m_bcnt = 0; m_fcnt = 0; m_rel = 0;
  endtask

  task automatic model_edge(input bit f, input bit s, input logic [EXW-1:0] idb);
    if (f) begin
      m_ex = '0; m_owed = FC - 1; m_rel = 0;
      if (m_fcnt < CNT_MAX) m_fcnt++;
    end else if (m_owed > 0) begin
      m_ex = '0; m_owed--; m_rel = 0;
      if (m_fcnt < CNT_MAX) m_fcnt++;
    end else if (s) begin
      m_ex = '0; m_rel = 1;
      if (m_bcnt < CNT_MAX) m_bcnt++;
    end else begin
      m_ex = idb; m_rel = 0;
    end
  endtask

  // Apply flush/stall for one edge, advance the model, sample 1 time unit later
  task automatic step(input bit f, input bit s);
    flush = f;
    hz_stall = s;
    @(posedge clk);
    model_edge(f, s, id_bus);
    #1;
  endtask

  task automatic rand_id();
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = AW'($urandom); id_rs2 = AW'($urandom); id_rd = AW'($urandom);
    id_ctrl = 10'($urandom); id_valid = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    flush = 0; hz_stall = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    model_clear();
  endtask

  task automatic test_reset();
    rand_id();
    @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_state: got %h want 0", obs);
    end
    @(negedge clk);
    reset = 0;
    model_clear();
  endtask

  task automatic test_capture();
    do_reset();
    rand_id();
    id_pc = 32'h100; id_ctrl = 10'h3C5; id_valid = 1;
    step(0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL capture: got %h want %h", obs, exp_v);
    end
    checks++;
    if ({ex_pc, ex_ctrl, ex_valid, hz_release} !== {32'h100, 10'h3C5, 1'b1, 1'b0}) begin
      errors++; $display("FAIL capture_fields: got pc=%h ctrl=%h v=%b rel=%b", ex_pc, ex_ctrl,
                         ex_valid, hz_release);
    end
  endtask

  task automatic test_single_stall();
    do_reset();
    rand_id();
    id_rd = 7; id_valid = 1;
    step(0, 1);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL single_stall_bubble: got %h want %h", obs, exp_v);
    end
    checks++;
    if ({ex_ctrl, ex_rd, ex_valid, hz_release, bubble_cnt} !== {10'h0, 5'd0, 1'b0, 1'b1, 4'd1})
    begin
      errors++; $display("FAIL single_stall_fields: got ctrl=%h rd=%0d v=%b rel=%b bc=%0d",
                         ex_ctrl, ex_rd, ex_valid, hz_release, bubble_cnt);
    end
    step(0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL single_stall_resume: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_stall_held();
    do_reset();
    rand_id();
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      checks++;
      if (obs !== exp_v || hz_release !== 1'b1) begin
        errors++; $display("FAIL stall_held_%0d: got %h want %h", i, obs, exp_v);
      end
    end
    checks++;
    if (bubble_cnt !== 4'd3) begin
      errors++; $display("FAIL stall_held_count: got %0d want 3", bubble_cnt);
    end
    rand_id();
    step(0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL stall_held_resume: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_flush_with_stall();
    do_reset();
    rand_id();
    step(1, 1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== exp_v || hz_release !== 1'b0) begin
        errors++; $display("FAIL flush_bubble_%0d: got %h want %h", i, obs, exp_v);
      end
      if (i == 0) step(0, 1);
    end
    checks++;
    if ({flush_cnt, bubble_cnt} !== {4'd2, 4'd0}) begin
      errors++; $display("FAIL flush_counts: got fc=%0d bc=%0d want fc=2 bc=0", flush_cnt,
                         bubble_cnt);
    end
    rand_id();
    step(0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL flush_resume: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rand_id();
    id_valid = 1;
    step(0, 0);
    step(0, 1);
    checks++;
    if (hz_release !== 1'b1) begin
      errors++; $display("FAIL async_pre_release: got %b want 1", hz_release);
    end
    #2;
    reset = 1;
    #1;
    checks++;
    if ({ex_valid, hz_release} !== 2'b00 || obs !== '0) begin
      errors++; $display("FAIL async_reset_clear: got %h want 0", obs);
    end
    @(negedge clk);
    reset = 0;
    model_clear();
    rand_id();
    step(0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL async_reset_run: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 16; i++) step(0, 1);
    checks++;
    if (bubble_cnt !== 4'd15 || obs !== exp_v) begin
      errors++; $display("FAIL bubble_saturate: got %0d want 15", bubble_cnt);
    end
    for (int i = 0; i < 9; i++) begin
      step(1, 0);
      step(0, 0);
    end
    checks++;
    if (flush_cnt !== 4'd15 || obs !== exp_v) begin
      errors++; $display("FAIL flush_saturate: got %0d want 15", flush_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rand_id();
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL random_%0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_capture();
    test_single_stall();
    test_stall_held();
    test_flush_with_stall();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
